fire_alarm_ctrl: RTL and testbench

Alarm sequencing controller that drives the `sig` command input of the 10 s countdown timer and consumes its `count` output. It debounces the smoke sensor, starts the countdown (pre-alarm), pauses it while smoke is briefly absent, escalates to full alarm when the count reaches zero, and handles user cancel/silence via `ack`. It sits between the sensor/button front end and the countdown timer and display.

---
 rtl/fire_alarm_ctrl.sv | 159 +++++++++++++++
 tb/tb_fire_alarm_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_alarm_ctrl.sv
// fire_alarm_ctrl
// Alarm sequencing controller sitting between the smoke sensor / user button
// and a 10 s countdown timer. It debounces smoke, runs the countdown while in
// pre-alarm, freezes it while smoke briefly clears, escalates to a full alarm
// when the countdown expires and handles cancel/silence via the ack button.
//
// Ports:
//   clk      in  1  single clock, all logic on posedge
//   reset    in  1  synchronous, active-high
//   smoke    in  1  synchronised smoke-sensor level
//   ack      in  1  user button level (cancel / silence)
//   count    in  8  current value of the countdown timer
//   sig      out 2  countdown command: 00 reload, 01 decrement, 10 freeze
//   prealarm out 1  high in PREALARM and HOLD
//   alarm    out 1  high in ALARM
//   buzzer   out 1  square wave in ALARM unless silenced
//   state    out 3  IDLE=0 DEBOUNCE=1 PREALARM=2 HOLD=3 ALARM=4
module fire_alarm_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int BUZZ_HALF       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       smoke,
    input  logic       ack,
    input  logic [7:0] count,
    output logic [1:0] sig,
    output logic       prealarm,
    output logic       alarm,
    output logic       buzzer,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_PREALARM = 3'd2,
        ST_HOLD     = 3'd3,
        ST_ALARM    = 3'd4
    } state_e;

    localparam logic [1:0] SIG_RELOAD = 2'b00;
    localparam logic [1:0] SIG_DEC    = 2'b01;
    localparam logic [1:0] SIG_FREEZE = 2'b10;

    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] BUZZ_LAST = 8'(BUZZ_HALF - 1);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       armed_q, armed_d;
    logic       silenced_q, silenced_d;
    logic       buzzer_q, buzzer_d;
    logic [1:0] sig_q;
    logic       prealarm_q;
    logic       alarm_q;
    logic       expiry;

    function automatic logic [1:0] sig_for(input state_e s);
        logic [1:0] r;
        case (s)
            ST_PREALARM:       r = SIG_DEC;
            ST_HOLD, ST_ALARM: r = SIG_FREEZE;
            default:           r = SIG_RELOAD;
        endcase
        return r;
    endfunction

    always_comb begin
        // armed guards against a stale zero count before the countdown has
        // actually been running for at least one edge.
        expiry     = (count == 8'd0) && armed_q;
        state_d    = state_q;
        timer_d    = timer_q;
        silenced_d = silenced_q;

        case (state_q)
            ST_IDLE: begin
                if (smoke) state_d = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!smoke)                  state_d = ST_IDLE;
                else if (timer_q == DEB_LAST) state_d = ST_PREALARM;
                else                         timer_d = timer_q + 8'd1;
            end
            ST_PREALARM: begin
                if (expiry)      state_d = ST_ALARM;
                else if (ack)    state_d = ST_IDLE;
                else if (!smoke) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (expiry)                    state_d = ST_ALARM;
                else if (ack)                  state_d = ST_IDLE;
                else if (smoke)                state_d = ST_PREALARM;
                else if (timer_q == HOLD_LAST) state_d = ST_IDLE;
                else                           timer_d = timer_q + 8'd1;
            end
            ST_ALARM: begin
                if (ack && !smoke) state_d = ST_IDLE;
                else if (ack)      silenced_d = 1'b1;
                // In ALARM the timer paces the buzzer half-period.
                if (timer_q == BUZZ_LAST) timer_d = 8'd0;
                else                      timer_d = timer_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Timer restarts on every state change; the first smoke sample in
        // IDLE already counts towards the debounce, hence 1.
        if (state_d != state_q) begin
            timer_d    = (state_d == ST_DEBOUNCE) ? 8'd1 : 8'd0;
            silenced_d = 1'b0;
        end

        armed_d = ((state_d == ST_PREALARM) || (state_d == ST_HOLD)) &&
                  (armed_q || (state_q == ST_PREALARM));

        buzzer_d = 1'b0;
        if (state_d == ST_ALARM) begin
            if (state_q != ST_ALARM)    buzzer_d = 1'b1;
            else if (silenced_d)        buzzer_d = 1'b0;
            else if (timer_q == BUZZ_LAST) buzzer_d = ~buzzer_q;
            else                        buzzer_d = buzzer_q;
        end
    end

    // Outputs are derived from the next state so they change on the same
    // edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= 8'd0;
            armed_q    <= 1'b0;
            silenced_q <= 1'b0;
            buzzer_q   <= 1'b0;
            sig_q      <= SIG_RELOAD;
            prealarm_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            armed_q    <= armed_d;
            silenced_q <= silenced_d;
            buzzer_q   <= buzzer_d;
            sig_q      <= sig_for(state_d);
            prealarm_q <= (state_d == ST_PREALARM) || (state_d == ST_HOLD);
            alarm_q    <= (state_d == ST_ALARM);
        end
    end

    assign sig      = sig_q;
    assign prealarm = prealarm_q;
    assign alarm    = alarm_q;
    assign buzzer   = buzzer_q;
    assign state    = state_q;

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// Testbench for fire_alarm_ctrl: a small countdown-timer stand-in drives
// count from sig; a run-length based reference model predicts outputs.
module tb_fire_alarm_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int BUZZ = 2;

    logic       clk = 1'b0;
    logic       reset, smoke, ack;
    logic [7:0] count;
    logic [1:0] sig;
    logic       prealarm, alarm, buzzer;
    logic [2:0] state;

    always #5 clk = ~clk;

    fire_alarm_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .BUZZ_HALF      (BUZZ)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .smoke   (smoke),
        .ack     (ack),
        .count   (count),
        .sig     (sig),
        .prealarm(prealarm),
        .alarm   (alarm),
        .buzzer  (buzzer),
        .state   (state)
    );

    // Countdown timer stand-in: reload to 10, decrement (stops at 0), freeze.
    logic [7:0] cnt_q = 8'd10;
    always @(posedge clk) begin
        if (sig == 2'b01)      cnt_q <= (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
        else if (sig == 2'b10) cnt_q <= cnt_q;
        else                   cnt_q <= 8'd10;
    end
    assign count = cnt_q;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: states as plain integers, debounce/hold tracked as
    // run lengths, buzzer derived from the age of the alarm.
    int m_st, m_run, m_low, m_age;
    bit m_armed, m_sil;

    task automatic model_step(input logic sm, input logic ak, input logic rs, input logic [7:0] c);
        int prev;
        bit exp_now;
        prev = m_st;
        if (rs) begin
            m_st = 0; m_run = 0; m_low = 0; m_age = 0; m_armed = 0; m_sil = 0;
        end else begin
            exp_now = (c == 8'd0) && m_armed;
            case (m_st)
                0: if (sm) begin m_st = 1; m_run = 1; end
                1: if (!sm) m_st = 0;
                   else begin m_run++; if (m_run == DEB) m_st = 2; end
                2: begin
                    m_armed = 1;
                    if (exp_now)  m_st = 4;
                    else if (ak)  m_st = 0;
                    else if (!sm) begin m_st = 3; m_low = 0; end
                end
                3: if (exp_now) m_st = 4;
                   else if (ak) m_st = 0;
                   else if (sm) m_st = 2;
                   else begin m_low++; if (m_low == HOLD) m_st = 0; end
                4: if (ak && !sm) m_st = 0;
                   else begin if (ak) m_sil = 1; m_age++; end
                default: m_st = 0;
            endcase
            if (m_st == 4 && prev != 4) begin m_age = 0; m_sil = 0; end
            if (m_st != 2 && m_st != 3) m_armed = 0;
        end
    endtask

    function automatic logic [1:0] m_sig();
        return (m_st <= 1) ? 2'd0 : (m_st == 2) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic m_buz();
        return (m_st == 4) && !m_sil && (((m_age / BUZZ) % 2) == 0);
    endfunction

    // One clock: drive at negedge, sample 1 time unit after posedge.
    task automatic cyc(input logic sm, input logic ak, input logic rs);
        logic [7:0] c;
        smoke = sm; ack = ak; reset = rs;
        c = count;
        @(posedge clk);
        #1;
        model_step(sm, ak, rs, c);
        chk("model_state",    state,    m_st);
        chk("model_sig",      sig,      m_sig());
        chk("model_prealarm", prealarm, (m_st == 2 || m_st == 3));
        chk("model_alarm",    alarm,    (m_st == 4));
        chk("model_buzzer",   buzzer,   m_buz());
        @(negedge clk);
    endtask

    task automatic go_prealarm();
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        repeat (DEB) cyc(1, 0, 0);
        chk("enter_pre_state", state, 3'd2);
    endtask

    typedef struct {
        logic       sm, ak, rs;
        logic [2:0] st;
        logic [1:0] sg;
        logic       pre, al, bz;
    } vec_t;

    vec_t tbl[30];

    initial begin
        int n;
        logic sm_r, ak_r, rs_r;

        reset = 1'b1; smoke = 1'b0; ack = 1'b0;

        // Reset, debounce glitch, full escalation, buzzer, silence, cancel.
        tbl[0]  = '{0,0,1, 3'd0,2'd0,0,0,0};
        tbl[1]  = '{0,0,1, 3'd0,2'd0,0,0,0};
        tbl[2]  = '{1,0,0, 3'd1,2'd0,0,0,0};
        tbl[3]  = '{1,0,0, 3'd1,2'd0,0,0,0};
        tbl[4]  = '{1,0,0, 3'd1,2'd0,0,0,0};
        tbl[5]  = '{0,0,0, 3'd0,2'd0,0,0,0};
        tbl[6]  = '{0,0,0, 3'd0,2'd0,0,0,0};
        tbl[7]  = '{1,0,0, 3'd1,2'd0,0,0,0};
        tbl[8]  = '{1,0,0, 3'd1,2'd0,0,0,0};
        tbl[9]  = '{1,0,0, 3'd1,2'd0,0,0,0};
        for (int i = 10; i <= 20; i++) tbl[i] = '{1,0,0, 3'd2,2'd1,1,0,0};
        tbl[21] = '{1,0,0, 3'd4,2'd2,0,1,1};
        tbl[22] = '{1,0,0, 3'd4,2'd2,0,1,1};
        tbl[23] = '{1,0,0, 3'd4,2'd2,0,1,0};
        tbl[24] = '{1,0,0, 3'd4,2'd2,0,1,0};
        tbl[25] = '{1,0,0, 3'd4,2'd2,0,1,1};
        tbl[26] = '{1,1,0, 3'd4,2'd2,0,1,0};
        tbl[27] = '{1,0,0, 3'd4,2'd2,0,1,0};
        tbl[28] = '{0,1,0, 3'd0,2'd0,0,0,0};
        tbl[29] = '{0,0,0, 3'd0,2'd0,0,0,0};

        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            cyc(tbl[i].sm, tbl[i].ak, tbl[i].rs);
            chk($sformatf("tbl%0d_state", i),    state,    tbl[i].st);
            chk($sformatf("tbl%0d_sig", i),      sig,      tbl[i].sg);
            chk($sformatf("tbl%0d_prealarm", i), prealarm, tbl[i].pre);
            chk($sformatf("tbl%0d_alarm", i),    alarm,    tbl[i].al);
            chk($sformatf("tbl%0d_buzzer", i),   buzzer,   tbl[i].bz);
        end

        // Pause/resume: 3 low samples starting at count 6 delays alarm by 3.
        go_prealarm();
        repeat (4) cyc(1, 0, 0);
        chk("pr_count6", count, 8'd6);
        repeat (3) cyc(0, 0, 0);
        chk("pr_hold_state", state, 3'd3);
        chk("pr_hold_count", count, 8'd5);
        chk("pr_hold_sig",   sig,   2'd2);
        cyc(1, 0, 0);
        chk("pr_resume_state", state, 3'd2);
        chk("pr_resume_count", count, 8'd5);
        n = 8;
        while (state != 3'd4 && n < 40) begin
            cyc(1, 0, 0);
            n++;
        end
        chk("pr_alarm_edge", n, 14);

        // Hold timeout: 8 low samples in HOLD return to IDLE, count reloads.
        go_prealarm();
        repeat (HOLD) cyc(0, 0, 0);
        chk("ht_still_hold", state, 3'd3);
        cyc(0, 0, 0);
        chk("ht_idle_state", state, 3'd0);
        chk("ht_idle_sig",   sig,   2'd0);
        cyc(0, 0, 0);
        chk("ht_reload", count, 8'd10);

        // Cancel in PREALARM at count 4.
        go_prealarm();
        repeat (6) cyc(1, 0, 0);
        chk("cx_count4", count, 8'd4);
        cyc(1, 1, 0);
        chk("cx_idle_state", state, 3'd0);
        chk("cx_prealarm",   prealarm, 1'b0);
        cyc(0, 0, 0);
        chk("cx_reload", count, 8'd10);

        // ack on the same edge expiry is sampled: expiry wins.
        go_prealarm();
        repeat (10) cyc(1, 0, 0);
        chk("ex_count0", count, 8'd0);
        cyc(1, 1, 0);
        chk("ex_alarm_state", state, 3'd4);
        chk("ex_alarm_out",   alarm, 1'b1);

        // Decrement to 0 on the HOLD-entry edge, then expiry from HOLD.
        go_prealarm();
        repeat (9) cyc(1, 0, 0);
        chk("he_count1", count, 8'd1);
        cyc(0, 0, 0);
        chk("he_hold_state", state, 3'd3);
        chk("he_hold_count", count, 8'd0);
        cyc(0, 0, 0);
        chk("he_alarm_state", state, 3'd4);

        // Reset while in ALARM.
        cyc(1, 0, 1);
        chk("ra_state",    state,    3'd0);
        chk("ra_sig",      sig,      2'd0);
        chk("ra_alarm",    alarm,    1'b0);
        chk("ra_buzzer",   buzzer,   1'b0);
        chk("ra_prealarm", prealarm, 1'b0);
        cyc(0, 0, 0);
        chk("ra_reload", count, 8'd10);

        // Randomised run against the reference model.
        sm_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (sm_r) sm_r = ($urandom_range(0, 9) != 0);
            else      sm_r = ($urandom_range(0, 4) == 0);
            ak_r = ($urandom_range(0, 15) == 0);
            rs_r = ($urandom_range(0, 399) == 0);
            cyc(sm_r, ak_r, rs_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
